// File: rtl/mdio_c45_mmd_backend.sv
// -----------------------------------------------------------------------------
// mdio_c45_mmd_backend
//
// Clause-45 MDIO backend between the MDIO frame deserialiser and a register
// bank. Serves NUM_MMD consecutive DEVADs (DEVAD_BASE..DEVAD_BASE+NUM_MMD-1)
// at a single PRTAD. Each served MMD has its own 16-bit address register.
// Read and write frames become a valid/ready request on the register
// interface. The request is abandoned after TIMEOUT_CYC cycles without ready.
//
// Optional feature macro: MDIO_C45_WR_INCR_EN
//   defined   : a completed WRITE also post-increments the MMD address register
//               (burst writes).
//   undefined : only READ_INC post-increments.
//
// Ports
//   clk_25m       in   1   system clock (only clock)
//   rst_n         in   1   synchronous active-low reset
//   enable        in   1   block enable; low acts as a synchronous clear
//   in_info       in  14   frame header: [11:10] OP, [9:5] PRTAD, [4:0] DEVAD
//   in_info_en    in   1   in_info strobe
//   in_data       in  16   address / write-data field
//   in_data_en    in   1   in_data strobe
//   reg_if_rdata  in  16   register read data, valid with reg_if_ready
//   reg_if_ready  in   1   request accept/complete
//   reg_if_addr   out 21   {DEVAD, address}
//   reg_if_wdata  out 16   write data
//   reg_if_valid  out  1   request pending
//   reg_if_we     out  1   1 = write, 0 = read
//   resp_rdata    out 16   read response data
//   resp_ready    out  1   one-cycle response strobe (reads only)
//   resp_err      out  1   one-cycle timeout strobe
//   busy          out  1   FSM not idle
// -----------------------------------------------------------------------------
module mdio_c45_mmd_backend #(
  parameter logic [4:0] PRTAD       = 5'd0,
  parameter logic [4:0] DEVAD_BASE  = 5'd1,
  parameter int         NUM_MMD     = 4,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [13:0] in_info,
  input  logic        in_info_en,
  input  logic [15:0] in_data,
  input  logic        in_data_en,
  input  logic [15:0] reg_if_rdata,
  input  logic        reg_if_ready,
  output logic [20:0] reg_if_addr,
  output logic [15:0] reg_if_wdata,
  output logic        reg_if_valid,
  output logic        reg_if_we,
  output logic [15:0] resp_rdata,
  output logic        resp_ready,
  output logic        resp_err,
  output logic        busy
);

  localparam int IDX_W = (NUM_MMD > 1) ? $clog2(NUM_MMD) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // 6-bit window bounds so DEVAD_BASE+NUM_MMD cannot overflow the compare.
  localparam logic [5:0] WIN_LO = {1'b0, DEVAD_BASE};
  localparam logic [5:0] WIN_HI = WIN_LO + 6'(NUM_MMD);

  localparam logic [1:0] OP_ADDRESS  = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ_INC = 2'b10;
  localparam logic [1:0] OP_READ     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_REQ,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        devad_q, devad_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [20:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rready_q, rready_d;
  logic              rerr_q, rerr_d;

  logic [15:0]       addr_reg_q [NUM_MMD];

  // Single write port into the per-MMD address registers.
  logic              addr_wr_en;
  logic [IDX_W-1:0]  addr_wr_idx;
  logic [15:0]       addr_wr_val;

  // Header decode.
  logic [1:0]        hdr_op;
  logic [4:0]        hdr_devad;
  logic [IDX_W-1:0]  hdr_idx;
  logic              hdr_hit;
  logic              hdr_accept;
  logic              take_hdr;
  logic              post_inc;
  logic              info_unused;

  assign hdr_op      = in_info[11:10];
  assign hdr_devad   = in_info[4:0];
  assign hdr_idx     = IDX_W'(hdr_devad - DEVAD_BASE);
  assign hdr_hit     = (in_info[9:5] == PRTAD) &&
                       ({1'b0, hdr_devad} >= WIN_LO) &&
                       ({1'b0, hdr_devad} <  WIN_HI);
  assign hdr_accept  = in_info_en && hdr_hit;
  assign info_unused = ^in_info[13:12];

`ifdef MDIO_C45_WR_INCR_EN
  assign post_inc = (op_q == OP_READ_INC) || (op_q == OP_WRITE);
`else
  assign post_inc = (op_q == OP_READ_INC);
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    devad_d     = devad_q;
    idx_d       = idx_q;
    to_cnt_d    = to_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    rready_d    = 1'b0;
    rerr_d      = 1'b0;
    addr_wr_en  = 1'b0;
    addr_wr_idx = idx_q;
    addr_wr_val = addr_reg_q[idx_q] + 16'd1;
    take_hdr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hdr_accept) begin
          take_hdr = 1'b1;
        end
      end

      ST_WAIT_DATA: begin
        // A data strobe completes the pending frame; a header strobe without
        // data aborts it and is treated as a brand-new frame.
        if (in_data_en) begin
          if (op_q == OP_ADDRESS) begin
            addr_wr_en  = 1'b1;
            addr_wr_val = in_data;
            state_d     = ST_IDLE;
          end else begin
            addr_d   = {devad_q, addr_reg_q[idx_q]};
            wdata_d  = in_data;
            we_d     = 1'b1;
            valid_d  = 1'b1;
            to_cnt_d = '0;
            state_d  = ST_REQ;
          end
        end else if (in_info_en) begin
          if (hdr_hit) begin
            take_hdr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_REQ: begin
        if (reg_if_ready) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d  = reg_if_rdata;
            rready_d = 1'b1;
          end
          addr_wr_en = post_inc;
        end else if (to_cnt_q == TO_LAST) begin
          // Timeout: reads still produce a response (all-ones data) so the
          // frontend can finish its frame; writes only flag the error.
          valid_d = 1'b0;
          state_d = ST_DONE;
          rerr_d  = 1'b1;
          if (!we_q) begin
            rdata_d  = 16'hFFFF;
            rready_d = 1'b1;
          end
          addr_wr_en = post_inc;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared frame-accept path for IDLE and the WAIT_DATA abort case.
    if (take_hdr) begin
      op_d    = hdr_op;
      devad_d = hdr_devad;
      idx_d   = hdr_idx;
      if ((hdr_op == OP_ADDRESS) || (hdr_op == OP_WRITE)) begin
        state_d = ST_WAIT_DATA;
      end else begin
        // Reads are issued straight from the header, before the data phase.
        addr_d   = {hdr_devad, addr_reg_q[hdr_idx]};
        we_d     = 1'b0;
        valid_d  = 1'b1;
        to_cnt_d = '0;
        state_d  = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk_25m) begin
    if (!rst_n || !enable) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      devad_q  <= '0;
      idx_q    <= '0;
      to_cnt_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      rready_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      devad_q  <= devad_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      rready_q <= rready_d;
      rerr_q   <= rerr_d;
    end
  end

  // Per-MMD address registers; cleared with the rest of the block.
  for (genvar gi = 0; gi < NUM_MMD; gi++) begin : g_addr_reg
    always_ff @(posedge clk_25m) begin
      if (!rst_n || !enable) begin
        addr_reg_q[gi] <= '0;
      end else if (addr_wr_en && (addr_wr_idx == IDX_W'(gi))) begin
        addr_reg_q[gi] <= addr_wr_val;
      end
    end
  end

  assign reg_if_addr  = addr_q;
  assign reg_if_wdata = wdata_q;
  assign reg_if_valid = valid_q;
  assign reg_if_we    = we_q;
  assign resp_rdata   = rdata_q;
  assign resp_ready   = rready_q;
  assign resp_err     = rerr_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdio_c45_mmd_backend.sv
// Scoreboard bench for mdio_c45_mmd_backend: the stimulus process predicts
// requests/responses from a per-DEVAD address model and queues them; a monitor
// pops and compares whenever the DUT raises a request or a response strobe; a
// bus responder answers requests with planned latency and data.
module tb_mdio_c45_mmd_backend;

  localparam logic [4:0] PRTAD       = 5'd0;
  localparam logic [4:0] DEVAD_BASE  = 5'd1;
  localparam int         NUM_MMD     = 4;
  localparam int         TIMEOUT_CYC = 64;

  localparam logic [1:0] OP_ADDR = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RDI  = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b11;

`ifdef MDIO_C45_WR_INCR_EN
  localparam bit WR_INC = 1'b1;
`else
  localparam bit WR_INC = 1'b0;
`endif

  typedef struct {
    logic [20:0] addr;
    logic [15:0] wdata;
    logic        we;
    int          len;   // expected cycles valid stays high; -1 = aborted
  } req_t;

  typedef struct {
    logic [15:0] rdata;
    logic        rdy;
    logic        err;
  } resp_t;

  typedef struct {
    int          lat;   // 0 = never answer
    logic [15:0] rd;
  } plan_t;

  logic        clk_25m = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [13:0] in_info = '0;
  logic        in_info_en = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_data_en = 1'b0;
  logic [15:0] reg_if_rdata;
  logic        reg_if_ready;
  logic [20:0] reg_if_addr;
  logic [15:0] reg_if_wdata;
  logic        reg_if_valid;
  logic        reg_if_we;
  logic [15:0] resp_rdata;
  logic        resp_ready;
  logic        resp_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  req_t  exp_req[$];
  resp_t exp_resp[$];
  plan_t plan_q[$];
  logic [15:0] model [32];

  mdio_c45_mmd_backend #(
    .PRTAD(PRTAD), .DEVAD_BASE(DEVAD_BASE), .NUM_MMD(NUM_MMD), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .enable(enable),
    .in_info(in_info), .in_info_en(in_info_en),
    .in_data(in_data), .in_data_en(in_data_en),
    .reg_if_rdata(reg_if_rdata), .reg_if_ready(reg_if_ready),
    .reg_if_addr(reg_if_addr), .reg_if_wdata(reg_if_wdata),
    .reg_if_valid(reg_if_valid), .reg_if_we(reg_if_we),
    .resp_rdata(resp_rdata), .resp_ready(resp_ready), .resp_err(resp_err),
    .busy(busy)
  );

  always #20 clk_25m = ~clk_25m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit served(input logic [4:0] prtad, input logic [4:0] devad);
    return (prtad == PRTAD) && (int'(devad) >= int'(DEVAD_BASE)) &&
           (int'(devad) < int'(DEVAD_BASE) + NUM_MMD);
  endfunction

  // Predict the outcome of one accepted frame from the protocol rules.
  task automatic expect_frame(input logic [1:0] op, input logic [4:0] devad,
                              input logic [15:0] data, input int lat, input logic [15:0] rd);
    req_t  r;
    resp_t p;
    plan_t b;
    if (op == OP_ADDR) begin
      model[devad] = data;
      return;
    end
    r.addr  = {devad, model[devad]};
    r.wdata = data;
    r.we    = (op == OP_WR);
    r.len   = (lat == 0) ? TIMEOUT_CYC : lat;
    exp_req.push_back(r);
    b.lat = lat;
    b.rd  = rd;
    plan_q.push_back(b);
    if (op == OP_WR) begin
      if (lat == 0) begin
        p.rdata = 16'h0; p.rdy = 1'b0; p.err = 1'b1;
        exp_resp.push_back(p);
      end
      if (WR_INC) model[devad] = model[devad] + 16'd1;
    end else begin
      p.rdata = (lat == 0) ? 16'hFFFF : rd;
      p.rdy   = 1'b1;
      p.err   = (lat == 0);
      exp_resp.push_back(p);
      if (op == OP_RDI) model[devad] = model[devad] + 16'd1;
    end
  endtask

  task automatic send_hdr(input logic [1:0] op, input logic [4:0] prtad, input logic [4:0] devad);
    @(posedge clk_25m); #1;
    in_info    = {2'($urandom), op, prtad, devad};
    in_info_en = 1'b1;
    @(posedge clk_25m); #1;
    in_info_en = 1'b0;
  endtask

  task automatic send_data(input logic [15:0] d);
    @(posedge clk_25m); #1;
    in_data    = d;
    in_data_en = 1'b1;
    @(posedge clk_25m); #1;
    in_data_en = 1'b0;
    in_data    = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_25m);
    while (busy && n < 300) begin
      @(negedge clk_25m);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(posedge clk_25m);
  endtask

  task automatic do_frame(input logic [1:0] op, input logic [4:0] prtad, input logic [4:0] devad,
                          input logic [15:0] data, input int lat, input logic [15:0] rd);
    if (served(prtad, devad)) expect_frame(op, devad, data, lat, rd);
    $display("frame op=%0d prtad=%0d devad=%0d data=%04h lat=%0d rd=%04h", op, prtad, devad, data, lat, rd);
    send_hdr(op, prtad, devad);
    if (op == OP_ADDR || op == OP_WR) send_data(data);
    wait_idle();
  endtask

  // Abort an in-flight request with either rst_n or enable, then check the clear.
  task automatic abort_mid_req(input bit use_rst);
    req_t  r;
    plan_t b;
    r.addr = {5'd1, model[1]}; r.wdata = '0; r.we = 1'b0; r.len = -1;
    exp_req.push_back(r);
    b.lat = 0; b.rd = '0;
    plan_q.push_back(b);
    send_hdr(OP_RD, PRTAD, 5'd1);
    repeat (5) @(posedge clk_25m);
    #1;
    if (use_rst) rst_n = 1'b0; else enable = 1'b0;
    @(posedge clk_25m); #1;
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk_25m);
    check("abort_valid", 32'(reg_if_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_resp", {30'd0, resp_ready, resp_err}, 32'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    wait_idle();
  endtask

  // Bus responder: raise ready in the planned cycle of each request; toggle
  // ready randomly while no request is pending (it must be ignored).
  initial begin
    plan_t p;
    int c = 0;
    p.lat = 0; p.rd = '0;
    reg_if_ready = 1'b0;
    reg_if_rdata = '0;
    forever begin
      @(negedge clk_25m);
      if (reg_if_valid === 1'b1) begin
        if (c == 0) begin
          if (plan_q.size() > 0) p = plan_q.pop_front();
          else begin p.lat = 0; p.rd = '0; end
        end
        c++;
        if (p.lat != 0 && c == p.lat) begin
          reg_if_ready = 1'b1;
          reg_if_rdata = p.rd;
        end else begin
          reg_if_ready = 1'b0;
          reg_if_rdata = 16'($urandom);
        end
      end else begin
        c = 0;
        reg_if_ready = ($urandom_range(0, 3) == 0);
        reg_if_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: compare each request and response strobe against the queues.
  initial begin
    req_t  cur;
    resp_t er;
    int    vcnt = 0;
    logic  prev_v = 1'b0;
    cur.addr = '0; cur.wdata = '0; cur.we = 1'b0; cur.len = -1;
    forever begin
      @(negedge clk_25m);
      if (reg_if_valid === 1'b1) begin
        if (!prev_v) begin
          vcnt = 0;
          if (exp_req.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
            cur.addr = reg_if_addr; cur.we = reg_if_we; cur.wdata = reg_if_wdata; cur.len = -1;
          end else begin
            cur = exp_req.pop_front();
          end
          $display("req addr=%06h we=%0b wdata=%04h exp_addr=%06h exp_len=%0d",
                   reg_if_addr, reg_if_we, reg_if_wdata, cur.addr, cur.len);
        end
        vcnt++;
        check("req_addr", 32'(reg_if_addr), 32'(cur.addr));
        check("req_we", 32'(reg_if_we), 32'(cur.we));
        if (cur.we) check("req_wdata", 32'(reg_if_wdata), 32'(cur.wdata));
      end else if (prev_v && cur.len >= 0) begin
        check("req_len", 32'(vcnt), 32'(cur.len));
      end
      prev_v = (reg_if_valid === 1'b1);
      if (resp_ready === 1'b1 || resp_err === 1'b1) begin
        $display("resp rdy=%0b err=%0b rdata=%04h", resp_ready, resp_err, resp_rdata);
        if (exp_resp.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          er = exp_resp.pop_front();
          check("resp_ready", 32'(resp_ready), 32'(er.rdy));
          check("resp_err", 32'(resp_err), 32'(er.err));
          if (er.rdy) check("resp_rdata", 32'(resp_rdata), 32'(er.rdata));
        end
      end
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(posedge clk_25m);
    @(negedge clk_25m);
    check("rst_valid", 32'(reg_if_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp", {30'd0, resp_ready, resp_err}, 32'd0);
    check("rst_addr", 32'(reg_if_addr), 32'd0);
    check("rst_rdata", 32'(resp_rdata), 32'd0);
    check("rst_we_wdata", {15'd0, reg_if_we, reg_if_wdata}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_25m);

    // Write through address register.
    do_frame(OP_ADDR, PRTAD, 5'd1, 16'h1234, 0, 16'h0);
    do_frame(OP_WR,   PRTAD, 5'd1, 16'hABCD, 3, 16'h0);
    // Post-read-increment sequence.
    do_frame(OP_ADDR, PRTAD, 5'd2, 16'h0010, 0, 16'h0);
    do_frame(OP_RDI,  PRTAD, 5'd2, 16'h0, 1, 16'h00A0);
    do_frame(OP_RDI,  PRTAD, 5'd2, 16'h0, 2, 16'h00A1);
    do_frame(OP_RDI,  PRTAD, 5'd2, 16'h0, 4, 16'h00A2);
    do_frame(OP_RD,   PRTAD, 5'd2, 16'h0, 1, 16'h5A5A);
    // Wrap at 16'hFFFF.
    do_frame(OP_ADDR, PRTAD, 5'd1, 16'hFFFF, 0, 16'h0);
    do_frame(OP_RDI,  PRTAD, 5'd1, 16'h0, 2, 16'h1111);
    do_frame(OP_RD,   PRTAD, 5'd1, 16'h0, 1, 16'h2222);
    do_frame(OP_RD,   PRTAD, 5'd1, 16'h0, 3, 16'h3333);
    // Timeouts.
    do_frame(OP_RD,   PRTAD, 5'd3, 16'h0, 0, 16'h0);
    do_frame(OP_RDI,  PRTAD, 5'd3, 16'h0, 0, 16'h0);
    do_frame(OP_WR,   PRTAD, 5'd3, 16'hBEEF, 0, 16'h0);
    // Frames outside PRTAD / DEVAD window are ignored.
    do_frame(OP_ADDR, 5'd3,  5'd1, 16'hDEAD, 0, 16'h0);
    do_frame(OP_RD,   5'd3,  5'd1, 16'h0, 1, 16'h0);
    do_frame(OP_ADDR, PRTAD, 5'd9, 16'hDEAD, 0, 16'h0);
    do_frame(OP_RD,   PRTAD, 5'd9, 16'h0, 1, 16'h0);
    do_frame(OP_WR,   PRTAD, 5'd0, 16'hDEAD, 1, 16'h0);
    do_frame(OP_RD,   PRTAD, 5'd5, 16'h0, 1, 16'h0);
    // Per-MMD independence.
    do_frame(OP_ADDR, PRTAD, 5'd1, 16'h0005, 0, 16'h0);
    do_frame(OP_ADDR, PRTAD, 5'd2, 16'h0007, 0, 16'h0);
    do_frame(OP_RD,   PRTAD, 5'd1, 16'h0, 1, 16'hC001);
    do_frame(OP_RD,   PRTAD, 5'd2, 16'h0, 2, 16'hC002);
    // WRITE header aborted by a READ header before its data.
    expect_frame(OP_RD, 5'd2, 16'h0, 2, 16'h4242);
    send_hdr(OP_WR, PRTAD, 5'd1);
    send_hdr(OP_RD, PRTAD, 5'd2);
    wait_idle();
    // Header and data during a pending request are ignored.
    expect_frame(OP_RD, 5'd1, 16'h0, 12, 16'h6161);
    send_hdr(OP_RD, PRTAD, 5'd1);
    send_hdr(OP_ADDR, PRTAD, 5'd2);
    send_data(16'h7777);
    wait_idle();
    do_frame(OP_RD,   PRTAD, 5'd2, 16'h0, 1, 16'h6262);
    // Synchronous reset and enable drop in the middle of a request.
    do_frame(OP_ADDR, PRTAD, 5'd1, 16'h0321, 0, 16'h0);
    abort_mid_req(1'b1);
    do_frame(OP_RD,   PRTAD, 5'd1, 16'h0, 1, 16'h7001);
    do_frame(OP_ADDR, PRTAD, 5'd4, 16'h0444, 0, 16'h0);
    abort_mid_req(1'b0);
    do_frame(OP_RD,   PRTAD, 5'd4, 16'h0, 2, 16'h7004);
    // Burst writes (post-increment only when the optional feature is built).
    do_frame(OP_ADDR, PRTAD, 5'd1, 16'h0020, 0, 16'h0);
    do_frame(OP_WR,   PRTAD, 5'd1, 16'h1001, 1, 16'h0);
    do_frame(OP_WR,   PRTAD, 5'd1, 16'h1002, 2, 16'h0);
    do_frame(OP_RD,   PRTAD, 5'd1, 16'h0, 1, 16'h8001);

    // Randomised frames.
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [4:0]  prtad;
      logic [4:0]  devad;
      int          lat;
      op    = 2'($urandom);
      prtad = ($urandom_range(0, 4) == 0) ? 5'd3 : PRTAD;
      devad = 5'($urandom_range(0, 6));
      lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      do_frame(op, prtad, devad, 16'($urandom), lat, 16'($urandom));
    end

    repeat (5) @(posedge clk_25m);
    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    check("plan_queue_drained", 32'(plan_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_c45_mmd_backend.md
Name: mdio_c45_mmd_backend

Overview:
- Parametrised next-generation Clause-45 MDIO backend; sits between the MDIO frame deserialiser (frontend) and the register-bank interface.
- Serves a window of NUM_MMD MMDs at one configurable PRTAD; keeps an independent 16-bit address register per MMD.
- Runs a valid/ready request handshake with timeout; generates read responses, post-read-increment and error flagging.

Parameters:
- PRTAD, 5'd0, port address this backend answers to.
- DEVAD_BASE, 5'd1, first served DEVAD.
- NUM_MMD, 4, number of served MMDs (1..32); served DEVADs are DEVAD_BASE..DEVAD_BASE+NUM_MMD-1.
- TIMEOUT_CYC, 64, maximum clk_25m cycles reg_if_valid waits for reg_if_ready (>=2).

Ports:
- clk_25m  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  block enable; low acts as soft synchronous clear.
- in_info  in  14  frame header: [11:10] OP, [9:5] PRTAD, [4:0] DEVAD; [13:12] ignored.
- in_info_en  in  1  one-cycle strobe, in_info valid.
- in_data  in  16  address or write data field.
- in_data_en  in  1  one-cycle strobe, in_data valid.
- reg_if_rdata  in  16  register read data, valid with reg_if_ready.
- reg_if_ready  in  1  request accept/complete.
- reg_if_addr  out  21  {DEVAD, addr}.
- reg_if_wdata  out  16  write data.
- reg_if_valid  out  1  request pending.
- reg_if_we  out  1  1 = write, 0 = read.
- resp_rdata  out  16  read response data.
- resp_ready  out  1  one-cycle response strobe.
- resp_err  out  1  one-cycle strobe with resp_ready on timeout.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low at posedge) or enable low: FSM to IDLE; all outputs 0; all address registers 0.
- OP decode: 00 ADDRESS, 01 WRITE, 11 READ, 10 READ_INC.
- Frame accept: in_info_en in IDLE with PRTAD match and DEVAD in window. Latch OP and DEVAD; idx = DEVAD-DEVAD_BASE.
- Non-matching PRTAD or DEVAD outside the window: frame ignored; no request, no response.
- FSM states: IDLE, WAIT_DATA, REQ, DONE.
- IDLE -> WAIT_DATA on ADDRESS/WRITE accept.
- IDLE -> REQ on READ/READ_INC accept. The request is raised the next cycle; the read is issued before the data phase.
- WAIT_DATA on in_data_en:
  - ADDRESS: addr_reg[idx] <= in_data; -> IDLE. No bus request.
  - WRITE: reg_if_addr <= {DEVAD, addr_reg[idx]}, reg_if_wdata <= in_data, we = 1; -> REQ.
- WAIT_DATA on in_info_en before data: old frame aborted; new header processed as a fresh accept in the same cycle.
- REQ: reg_if_valid held high with stable addr/wdata/we until reg_if_ready is sampled high, then deasserted next cycle; -> DONE.
- Read completion: resp_rdata <= reg_if_rdata; resp_ready pulses 1 cycle, 1 cycle after ready.
- Write completion: no resp_ready.
- Timeout: counter starts at 0 on entering REQ. At TIMEOUT_CYC without ready: valid drops, -> DONE.
  - Read: resp_rdata = 16'hFFFF, resp_ready = 1 and resp_err = 1 together for one cycle.
  - Write: resp_err pulses alone.
- READ_INC: after completion (ready or timeout), addr_reg[idx] <= addr_reg[idx]+1, wrapping 16'hFFFF -> 16'h0000. READ and WRITE never change addr_reg.
- DONE -> IDLE unconditionally after one cycle.
- in_info_en in REQ/DONE: ignored. Frontend frame spacing (>=64 bit times) guarantees no loss.
- reg_if_ready while valid low: ignored.
- enable dropped mid-request: valid drops next cycle; no response.
- Read latency, header strobe -> reg_if_valid: 1 cycle.

Optional Feature:
- Macro MDIO_C45_WR_INCR_EN.
- Defined: a completed WRITE (ready or timeout) also post-increments addr_reg[idx] with the same wrap rule, enabling burst writes.
- Undefined: WRITE leaves addr_reg unchanged.

Test Plan:
- ADDRESS DEVAD=1 data 16'h1234, then WRITE DEVAD=1 data 16'hABCD, ready after 3 cycles -> one request addr=21'h011234, wdata=16'hABCD, we=1; valid held 3 cycles; no resp_ready.
- ADDRESS DEVAD=2 16'h0010; READ_INC x3; rdata 16'hA0/A1/A2 -> requests at addr 0x10/0x11/0x12; resp_rdata 16'hA0/A1/A2; final addr_reg[1]=16'h0013.
- ADDRESS DEVAD=1 16'hFFFF; READ_INC -> request addr 21'h01FFFF; then READ -> addr 21'h010000 (wrap); the READ leaves addr unchanged.
- READ with ready never asserted, TIMEOUT_CYC=64 -> valid high exactly 64 cycles; resp_rdata=16'hFFFF, resp_ready=resp_err=1 for one cycle.
- Frames with PRTAD=5'd3, or DEVAD=5'd9 with NUM_MMD=4 -> no reg_if_valid, no resp_ready, addr regs unchanged. Per-MMD independence: ADDRESS DEVAD1=0x5, DEVAD2=0x7; READ DEVAD1 -> addr 21'h010005.
- rst_n low for one posedge mid-REQ -> next cycle valid=0, busy=0, addr regs 0. With MDIO_C45_WR_INCR_EN defined, two WRITEs after ADDRESS 0x20 -> addrs 0x20, 0x21.
